// File: rtl/commit_wb_arbiter_if.sv
// rtl/commit_wb_arbiter_if.sv - commit-request and writeback handshake bundle
//
// Purpose: groups the per-requester commit channels and the single writeback
// channel that commit_wb_arbiter sits between.
//
// Signals:
//   req_valid  [NUM_REQS]               commit valid, one bit per requester
//   req_wid    [NUM_REQS*WID_W]         warp id, requester i in slice i
//   req_tmask  [NUM_REQS*NUM_THREADS]   thread mask
//   req_rd     [NUM_REQS*5]             destination register
//   req_data   [NUM_REQS*NUM_THREADS*32] per-lane writeback data
//   req_ready  [NUM_REQS]               one-hot accept back to requesters
//   wb_valid/wb_wid/wb_tmask/wb_rd/wb_data  granted writeback payload
//   wb_ready                            writeback sink ready
//
// Modports: master = execute units plus writeback sink (the environment),
//           slave  = the arbiter.

interface commit_wb_arbiter_if #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int WID_W       = 2
);
    logic [NUM_REQS-1:0]                req_valid;
    logic [NUM_REQS*WID_W-1:0]          req_wid;
    logic [NUM_REQS*NUM_THREADS-1:0]    req_tmask;
    logic [NUM_REQS*5-1:0]              req_rd;
    logic [NUM_REQS*NUM_THREADS*32-1:0] req_data;
    logic [NUM_REQS-1:0]                req_ready;

    logic                               wb_valid;
    logic [WID_W-1:0]                   wb_wid;
    logic [NUM_THREADS-1:0]             wb_tmask;
    logic [4:0]                         wb_rd;
    logic [NUM_THREADS*32-1:0]          wb_data;
    logic                               wb_ready;

    modport master (
        output req_valid, req_wid, req_tmask, req_rd, req_data, wb_ready,
        input  req_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data
    );

    modport slave (
        input  req_valid, req_wid, req_tmask, req_rd, req_data, wb_ready,
        output req_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data
    );
endinterface

// File: rtl/commit_wb_arbiter.sv
// rtl/commit_wb_arbiter.sv - round-robin commit-to-writeback arbiter
//
// Purpose: shares the single register-file writeback port among the execute
// commit streams (0 = alu, 1 = ld, 2 = csr, 3 = fpu, 4 = gpu) using a
// round-robin grant, a registered output stage and a saturating counter of
// contended cycles.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous active-high reset
//   bus           commit_wb_arbiter_if.slave: req_* in, req_ready out,
//                 wb_* out, wb_ready in
//   conflict_cnt  cycles with at least one valid-but-unaccepted requester

module commit_wb_arbiter #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int WID_W       = 2,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    commit_wb_arbiter_if.slave    bus,
    output logic [CNT_W-1:0]      conflict_cnt
);
    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int DATA_W = NUM_THREADS * 32;

    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [NUM_REQS-1:0]    grant_oh;
    logic                   load_en;
    logic [NUM_REQS-1:0]    ready_vec;
    logic [NUM_REQS-1:0]    waiting;

    logic [WID_W-1:0]       sel_wid;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [4:0]             sel_rd;
    logic [DATA_W-1:0]      sel_data;

    logic                   wb_valid_q;
    logic [WID_W-1:0]       wb_wid_q;
    logic [NUM_THREADS-1:0] wb_tmask_q;
    logic [4:0]             wb_rd_q;
    logic [DATA_W-1:0]      wb_data_q;

    // The output register can take a new entry when it is empty or when its
    // current entry drains this same edge.
    assign load_en = !wb_valid_q || bus.wb_ready;

    // Scan starting one past the last granted index so the previous winner
    // has lowest priority on the next acceptance.
    always_comb begin
        int               scan;
        logic [IDX_W-1:0] scan_idx;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        scan      = 0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            scan     = (int'(last_grant) + 1 + k) % NUM_REQS;
            scan_idx = IDX_W'(scan);
            if (!grant_any && bus.req_valid[scan_idx]) begin
                grant_any          = 1'b1;
                grant_idx          = scan_idx;
                grant_oh[scan_idx] = 1'b1;
            end
        end
    end

    // req_ready is combinational; forcing it low under reset keeps
    // requesters from believing they were accepted while state is cleared.
    always_comb begin
        ready_vec = '0;
        if (!reset) begin
            ready_vec = grant_oh & {NUM_REQS{load_en}};
        end
    end

    assign bus.req_ready = ready_vec;
    assign waiting       = bus.req_valid & ~ready_vec;

    always_comb begin
        sel_wid   = bus.req_wid[int'(grant_idx)*WID_W +: WID_W];
        sel_tmask = bus.req_tmask[int'(grant_idx)*NUM_THREADS +: NUM_THREADS];
        sel_rd    = bus.req_rd[int'(grant_idx)*5 +: 5];
        sel_data  = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
    end

    // Output stage and round-robin pointer. last_grant only moves on a real
    // acceptance so stalls never rotate priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_wid_q   <= '0;
            wb_tmask_q <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            last_grant <= IDX_W'(NUM_REQS - 1);
        end else if (load_en) begin
            if (grant_any) begin
                wb_valid_q <= 1'b1;
                wb_wid_q   <= sel_wid;
                wb_tmask_q <= sel_tmask;
                wb_rd_q    <= sel_rd;
                wb_data_q  <= sel_data;
                last_grant <= grant_idx;
            end else begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_wid   = wb_wid_q;
    assign bus.wb_tmask = wb_tmask_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;

    // Saturating contention counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if ((|waiting) && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_commit_wb_arbiter.sv
// tb/tb_commit_wb_arbiter.sv - self-checking bench for commit_wb_arbiter

module tb_commit_wb_arbiter;
    localparam int N  = 5;
    localparam int T  = 4;
    localparam int W  = 2;
    localparam int DW = T * 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    commit_wb_arbiter_if #(.NUM_REQS(N), .NUM_THREADS(T), .WID_W(W)) bus ();
    commit_wb_arbiter_if #(.NUM_REQS(N), .NUM_THREADS(T), .WID_W(W)) bus4 ();

    logic [31:0] cnt;
    logic [3:0]  cnt4;

    commit_wb_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .WID_W(W), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .conflict_cnt(cnt)
    );

    commit_wb_arbiter #(.NUM_REQS(N), .NUM_THREADS(T), .WID_W(W), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .conflict_cnt(cnt4)
    );

    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_wid   = bus.req_wid;
    assign bus4.req_tmask = bus.req_tmask;
    assign bus4.req_rd    = bus.req_rd;
    assign bus4.req_data  = bus.req_data;
    assign bus4.wb_ready  = bus.wb_ready;

    // Requester-side stimulus state
    bit            rv   [N];
    logic [W-1:0]  rwid [N];
    logic [T-1:0]  rtm  [N];
    logic [4:0]    rrd  [N];
    logic [DW-1:0] rdat [N];

    // Reference model state
    int            m_last;
    bit            m_valid;
    logic [W-1:0]  m_wid;
    logic [T-1:0]  m_tm;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_dat;
    longint        m_cnt;
    int            m_acc;

    int vectors     = 0;
    int miscompares = 0;

    task automatic new_payload(input int i);
        rwid[i] = W'($urandom);
        rtm[i]  = T'($urandom);
        rrd[i]  = 5'($urandom);
        rdat[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = rv[i];
            bus.req_wid[i*W +: W]     = rwid[i];
            bus.req_tmask[i*T +: T]   = rtm[i];
            bus.req_rd[i*5 +: 5]      = rrd[i];
            bus.req_data[i*DW +: DW]  = rdat[i];
        end
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= N; k++) begin
            if (rv[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last  = N - 1;
        m_valid = 1'b0;
        m_cnt   = 0;
        m_acc   = -1;
    endtask

    // One clock: check everything against the model just before the edge,
    // advance the model across the edge, return at the next falling edge.
    task automatic step();
        int            g;
        bit            load;
        bit            any_wait;
        logic [N-1:0]  exp_ready;
        logic [3:0]    exp4;
        logic [31:0]   exp32;
        apply();
        #1;
        load      = !m_valid || bus.wb_ready;
        g         = model_grant();
        exp_ready = '0;
        if (load && g >= 0) exp_ready[g] = 1'b1;
        exp32 = m_cnt[31:0];
        exp4  = (m_cnt > 15) ? 4'd15 : m_cnt[3:0];

        vectors++;
        if (bus.req_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
        end
        vectors++;
        if (bus.wb_valid !== m_valid) begin
            miscompares++;
            $display("FAIL wb_valid: got %b expected %b", bus.wb_valid, m_valid);
        end
        if (m_valid) begin
            vectors++;
            if ({bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data} !== {m_wid, m_tm, m_rd, m_dat}) begin
                miscompares++;
                $display("FAIL wb_payload: got wid=%0d tm=%h rd=%0d data=%h expected wid=%0d tm=%h rd=%0d data=%h",
                         bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data, m_wid, m_tm, m_rd, m_dat);
            end
        end
        vectors++;
        if (cnt !== exp32) begin
            miscompares++;
            $display("FAIL conflict_cnt: got %0d expected %0d", cnt, exp32);
        end
        vectors++;
        if (cnt4 !== exp4) begin
            miscompares++;
            $display("FAIL conflict_cnt4: got %0d expected %0d", cnt4, exp4);
        end

        @(posedge clk);
        any_wait = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rv[i] && !exp_ready[i]) any_wait = 1'b1;
        end
        if (any_wait) m_cnt++;
        m_acc = -1;
        if (load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_wid   = rwid[g];
                m_tm    = rtm[g];
                m_rd    = rrd[g];
                m_dat   = rdat[g];
                m_last  = g;
                m_acc   = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: random traffic, 1: keep everyone valid, 2: drop on acceptance
    task automatic refresh(input int mode);
        for (int i = 0; i < N; i++) begin
            if (m_acc == i) begin
                if (mode == 2) rv[i] = 1'b0;
                else if (mode == 0) rv[i] = 1'($urandom % 2);
                new_payload(i);
            end else if (!rv[i] && mode == 0 && ($urandom % 3) == 0) begin
                rv[i] = 1'b1;
                new_payload(i);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            new_payload(i);
        end
        bus.wb_ready = 1'b1;
        reset = 1'b1;
        apply();
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b expected 00000", bus.req_ready);
        end
        vectors++;
        if ({bus.wb_valid, bus.wb_wid, bus.wb_tmask, bus.wb_rd, bus.wb_data, cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b rd=%0d cnt=%0d expected all zero",
                     bus.wb_valid, bus.wb_rd, cnt);
        end
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        do_reset();
        repeat (10) step();
    endtask

    task automatic test_single();
        do_reset();
        bus.wb_ready = 1'b1;
        new_payload(0);
        rv[0]   = 1'b1;
        rwid[0] = 2'd1;
        rrd[0]  = 5'd7;
        step();
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_wid !== 2'd1 || cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL single_latency: got valid=%b rd=%0d wid=%0d cnt=%0d expected 1 7 1 0",
                     bus.wb_valid, bus.wb_rd, bus.wb_wid, cnt);
        end
        refresh(2);
        repeat (3) step();
    endtask

    task automatic test_all_valid();
        int order [6] = '{0, 1, 2, 3, 4, 0};
        logic [N-1:0] exp_oh;
        do_reset();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            new_payload(i);
        end
        for (int c = 0; c < 6; c++) begin
            apply();
            #1;
            exp_oh = '0;
            exp_oh[order[c]] = 1'b1;
            vectors++;
            if (bus.req_ready !== exp_oh) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %b expected %b", c, bus.req_ready, exp_oh);
            end
            step();
            refresh(1);
        end
        vectors++;
        if (cnt !== 32'd6) begin
            miscompares++;
            $display("FAIL rr_conflicts: got %0d expected 6", cnt);
        end
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        step();
    endtask

    task automatic test_stall();
        logic [4:0] rd1;
        do_reset();
        for (int i = 0; i < N; i++) new_payload(i);
        rv[1] = 1'b1;
        rv[3] = 1'b1;
        rd1 = rrd[1];
        bus.wb_ready = 1'b1;
        step();
        refresh(2);
        bus.wb_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if (bus.wb_rd !== rd1 || cnt !== 32'd4) begin
            miscompares++;
            $display("FAIL stall_hold: got rd=%0d cnt=%0d expected rd=%0d cnt=4", bus.wb_rd, cnt, rd1);
        end
        bus.wb_ready = 1'b1;
        apply();
        #1;
        vectors++;
        if (bus.req_ready !== 5'b01000) begin
            miscompares++;
            $display("FAIL stall_next_grant: got %b expected 01000", bus.req_ready);
        end
        step();
        refresh(2);
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            new_payload(i);
        end
        repeat (15) begin
            step();
            refresh(1);
        end
        vectors++;
        if (cnt4 !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_reach: got %0d expected 15", cnt4);
        end
        repeat (5) begin
            step();
            refresh(1);
        end
        vectors++;
        if (cnt4 !== 4'd15 || cnt !== 32'd20) begin
            miscompares++;
            $display("FAIL sat_hold: got cnt4=%0d cnt=%0d expected 15 and 20", cnt4, cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b1;
            new_payload(i);
        end
        repeat (3) begin
            step();
            refresh(1);
        end
        vectors++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== m_rd || m_acc != 2) begin
            miscompares++;
            $display("FAIL mid_pending: got valid=%b rd=%0d expected 1 rd=%0d from req2",
                     bus.wb_valid, bus.wb_rd, m_rd);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async_drop: got %b expected 0", bus.wb_valid);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        apply();
        #1;
        vectors++;
        if (bus.req_ready !== 5'b00001) begin
            miscompares++;
            $display("FAIL mid_regrant: got %b expected 00001", bus.req_ready);
        end
        step();
        refresh(2);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < N; i++) rv[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.wb_ready = ($urandom % 4) != 0;
            step();
            refresh(0);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.wb_ready  = 1'b0;
        bus.req_valid = '0;
        bus.req_wid   = '0;
        bus.req_tmask = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            rv[i] = 1'b0;
            new_payload(i);
        end
        model_reset();
        test_reset();
        test_single();
        test_all_valid();
        test_stall();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
